seq_det_param: RTL and testbench
================================

# seq_det_param

Parametrised Mealy serial sequence detector, the generalised successor to the fixed 1010 detectors in the FSM set. The pattern, its length and the overlap mode are loadable at run time. Each bit of the serial stream is qualified by a valid strobe. The block drives a combinational Mealy match pulse, a registered copy of that pulse, and a saturating match counter. It sits between a serial bit source and any logic that consumes match events or statistics.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits; must be ≥ 2.
- CNT_W, default 8: width of the match counter.
- DEF_PAT, default 8'b0000_1010: pattern loaded at reset, right-aligned.
- DEF_LEN, default 4: pattern length loaded at reset.
- DEF_OVL, default 0: overlap mode loaded at reset (0 = non-overlapping, 1 = overlapping).

- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset; asynchronous, active-low.
- In  in  1  serial data bit.
- In_Vld  in  1  In is sampled only when this is 1.
- Pat_Ld  in  1  load strobe for Pat_In, Len_In and Ovl_In.
- Pat_In  in  MAX_LEN  new pattern, right-aligned. Bit Len-1 is the first bit received; bit 0 is the last.
- Len_In  in  clog2(MAX_LEN)+1  new pattern length.
- Ovl_In  in  1  new overlap mode.
- OP  out  1  Mealy match; combinational from In, In_Vld and registered state.
- OP_Reg  out  1  OP delayed by one cycle.
- Cnt  out  CNT_W  number of matches, saturating.
- Cnt_Sat  out  1  Cnt is at its maximum value.

## Operation
- State registers:
  - Pat: pattern.
  - Len: effective length.
  - Ovl: overlap mode.
  - Hist: MAX_LEN-1 bits, most recent bit in bit 0.
  - Fill: count of valid history bits, saturating at MAX_LEN-1.
  - OP_Reg.
  - Cnt.
- Len_In on load:
  - Len_In = 0: stored as 0; the block never matches.
  - Len_In > MAX_LEN: clamped to MAX_LEN.
- Candidate word: {Hist, In}, compared over its low Len bits against Pat[Len-1:0].
- OP = In_Vld & ~Pat_Ld & (Len ≠ 0) & (Fill ≥ Len-1) & (candidate word equals pattern).
- When In_Vld = 1 and Pat_Ld = 0:
  - Hist shifts left and takes In into bit 0.
  - If OP = 1 and Ovl = 0: Fill is cleared to 0 (non-overlapping restart).
  - Otherwise Fill increments, saturating at MAX_LEN-1.
- When In_Vld = 0: Hist and Fill hold; OP = 0.
- When Pat_Ld = 1, it takes priority over In_Vld:
  - Pat, Len and Ovl load from their inputs.
  - Hist, Fill and Cnt clear.
  - OP_Reg clears.
  - The In bit is discarded.
- Cnt increments on each cycle with OP = 1 and saturates at 2^CNT_W - 1. Cnt_Sat = (Cnt == all ones).
- Conceptual states are defined by Fill: EMPTY (0), PARTIAL (1 to Len-2), ARMED (≥ Len-1). Only ARMED can assert OP. A non-overlapping match returns to EMPTY.
- Len = 1: Fill is always ≥ 0, so every valid bit equal to Pat[0] matches, in either mode.

## Timing
- Reset (Rst = 0, asynchronous):
  - Hist = 0, Fill = 0, OP_Reg = 0, Cnt = 0, Cnt_Sat = 0.
  - Pat = DEF_PAT, Len = DEF_LEN, Ovl = DEF_OVL.
  - OP = 0, because Fill = 0 and Len > 1.
- OP latency: zero cycles; OP is valid in the same cycle as the final bit, before the edge.
- OP_Reg and Cnt update on the edge that consumes the final bit.
- A new pattern is used for the first valid bit after the Pat_Ld edge.
- Reset asserted mid-sequence discards partial history; a full pattern must be received again after release.
- No handshake back-pressure: every valid bit is consumed in one cycle, one bit per clock maximum.

## Structure
- Shared package `seq_det_pkg`:
  - LEN_W = clog2(MAX_LEN)+1.
  - Mode constants OVL_OFF = 0, OVL_ON = 1.
  - Default pattern constants.
- One natural sub-module: `sat_counter` (parameter W; inputs inc and clr; outputs cnt and sat), used for Cnt.
- Everything else is one two-process design: a sequential block for the registers and a combinational block for OP and the next-state values.

## Test plan
- Reset defaults (1010, length 4, non-overlapping), stream 1,0,1,0,1,0 with In_Vld = 1 → OP high on bit 4 only; Cnt = 1.
- Load Ovl_In = 1, same stream → OP high on bits 4 and 6; Cnt = 2; OP_Reg follows OP one cycle later.
- Stream 1,0,1 with a 3-cycle In_Vld = 0 gap, then 0 → OP on the final 0 only; during the gap OP = 0 and Hist holds.
- Stream 1,0,1, then Rst pulse low for 3 ns between edges, then 0 → no match; Cnt = 0.
- CNT_W = 2, Len_In = 1, Pat_In = 1, stream of five 1s → OP on every bit; Cnt = 3; Cnt_Sat = 1 after the third match.
- Pat_Ld = 1 with In_Vld = 1 and In = 1 after a partial 1,0,1 → no OP; Fill = 0; Cnt = 0. Len_In = 12 with MAX_LEN = 8 loads as Len = 8.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parametrised serial sequence detector.
// Holds the reset defaults, the overlap-mode encodings and the length-field width helper.
package seq_det_pkg;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam logic [7:0]  DEF_PATTERN = 8'b0000_1010;
    localparam int unsigned DEF_PAT_LEN = 4;

    // Conceptual detector state, derived from the history fill level.
    typedef enum logic [1:0] {
        StEmpty,
        StPartial,
        StArmed
    } fill_state_e;

    // Width of a length field able to hold 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; the clear wins over the increment.
// Holds at all ones once reached.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Run-time loadable Mealy serial sequence detector with overlap control,
// a registered match copy and a saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned          CNT_W   = 8,
    parameter logic [MAX_LEN-1:0]   DEF_PAT = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned          DEF_LEN = DEF_PAT_LEN,
    parameter logic                 DEF_OVL = OVL_OFF,
    localparam int unsigned         LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in,
    input  logic               in_vld,
    input  logic               pat_ld,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               ovl_in,
    output logic               op,
    output logic               op_reg,
    output logic [CNT_W-1:0]   cnt,
    output logic               cnt_sat
);

    localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FillMax = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               op_reg_q, op_reg_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    logic               op_c;
    fill_state_e        fill_state;

    always_comb begin
        cand = {hist_q, in};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        match = ((cand ^ pat_q) & mask) == '0;

        // Len = 1 is armed even with an empty history.
        if ((len_q != '0) && (fill_q >= (len_q - LEN_W'(1)))) begin
            fill_state = StArmed;
        end else if (fill_q == '0) begin
            fill_state = StEmpty;
        end else begin
            fill_state = StPartial;
        end

        op_c = in_vld && !pat_ld && (fill_state == StArmed) && match;

        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        op_reg_d = op_c;

        if (pat_ld) begin
            pat_d    = pat_in;
            len_d    = (len_in > LenMax) ? LenMax : len_in;
            ovl_d    = ovl_in;
            hist_d   = '0;
            fill_d   = '0;
            op_reg_d = 1'b0;
        end else if (in_vld) begin
            hist_d = cand[MAX_LEN-2:0];
            if (op_c && (ovl_q == OVL_OFF)) begin
                fill_d = '0;
            end else if (fill_q != FillMax) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= DEF_PAT;
            len_q    <= LEN_W'(DEF_LEN);
            ovl_q    <= DEF_OVL;
            hist_q   <= '0;
            fill_q   <= '0;
            op_reg_q <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            op_reg_q <= op_reg_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (op_c),
        .clr   (pat_ld),
        .cnt   (cnt),
        .sat   (cnt_sat)
    );

    assign op     = op_c;
    assign op_reg = op_reg_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Randomised scoreboard bench for seq_det_param: a bit-queue reference model predicts each
// cycle's outputs, and a negedge monitor pops and compares them against the DUT.
module tb_seq_det_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_vld = 1'b0;
    logic             pat_ld = 1'b0;
    logic [7:0]       pat_in = '0;
    logic [LEN_W-1:0] len_in = '0;
    logic             ovl_in = 1'b0;
    logic             op;
    logic             op_reg;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;

    seq_det_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_bit),
        .in_vld  (in_vld),
        .pat_ld  (pat_ld),
        .pat_in  (pat_in),
        .len_in  (len_in),
        .ovl_in  (ovl_in),
        .op      (op),
        .op_reg  (op_reg),
        .cnt     (cnt),
        .cnt_sat (cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             op;
        logic             op_reg;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model: pattern, bits received since the last restart, match count.
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl;
    bit         m_bits[$];
    int         m_cnt;
    logic       m_op_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat    = 8'b0000_1010;
        m_len    = 4;
        m_ovl    = 1'b0;
        m_bits.delete();
        m_cnt    = 0;
        m_op_reg = 1'b0;
    endtask

    // A match: the last m_len received bits, oldest first, spell pattern bit m_len-1 down to 0.
    function automatic logic model_match(input logic b);
        bit tmp[$];
        if (m_len == 0) return 1'b0;
        tmp = m_bits;
        tmp.push_back(b);
        if (tmp.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (tmp[tmp.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t cur_exp(input logic eop);
        exp_t e;
        e.op     = eop;
        e.op_reg = m_op_reg;
        e.cnt    = CNT_W'(m_cnt);
        e.sat    = (m_cnt == CNT_MAX);
        return e;
    endfunction

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic vld, input logic b, input logic ld,
                        input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o);
        logic eop;
        eop = (!ld && vld) ? model_match(b) : 1'b0;
        in_vld = vld;
        in_bit = b;
        pat_ld = ld;
        pat_in = p;
        len_in = l;
        ovl_in = o;
        sb.push_back(cur_exp(eop));
        @(posedge clk);
        #1;
        if (ld) begin
            m_pat    = p;
            m_len    = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
            m_ovl    = o;
            m_bits.delete();
            m_cnt    = 0;
            m_op_reg = 1'b0;
        end else begin
            m_op_reg = eop;
            if (eop && m_cnt < CNT_MAX) m_cnt++;
            if (vld) begin
                if (eop && !m_ovl) begin
                    m_bits.delete();
                end else begin
                    m_bits.push_back(b);
                    while (m_bits.size() > MAX_LEN - 1) void'(m_bits.pop_front());
                end
            end
        end
    endtask

    task automatic bit_in(input logic b);
        step(1'b1, b, 1'b0, pat_in, len_in, ovl_in);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, pat_in, len_in, ovl_in);
    endtask

    task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o);
        step(1'b0, 1'b0, 1'b1, p, l, o);
    endtask

    task automatic stream(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask

    // Short asynchronous reset pulse between the negedge sample and the next posedge.
    task automatic rst_pulse();
        in_vld = 1'b0;
        pat_ld = 1'b0;
        sb.push_back(cur_exp(1'b0));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("op", 32'(op), 32'(mon_e.op));
            check("op_reg", 32'(op_reg), 32'(mon_e.op_reg));
            check("cnt", 32'(cnt), 32'(mon_e.cnt));
            check("cnt_sat", 32'(cnt_sat), 32'(mon_e.sat));
        end
    end

    initial begin
        logic [7:0]       rp;
        logic [LEN_W-1:0] rl;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_op", 32'(op), 0);
        check("reset_op_reg", 32'(op_reg), 0);
        check("reset_cnt", 32'(cnt), 0);
        check("reset_cnt_sat", 32'(cnt_sat), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Defaults: 1010, non-overlapping.
        stream(8'b10_1010, 6);
        check("t1_cnt", 32'(cnt), 1);

        // Overlapping mode.
        load(8'b1010, 4, 1'b1);
        stream(8'b10_1010, 6);
        check("t2_cnt", 32'(cnt), 2);

        // Valid gap holds history.
        load(8'b1010, 4, 1'b0);
        stream(8'b101, 3);
        repeat (3) idle();
        bit_in(1'b0);
        check("t3_cnt", 32'(cnt), 1);
        check("t3_op_reg", 32'(op_reg), 1);

        // Reset mid-sequence discards history.
        load(8'b1010, 4, 1'b0);
        stream(8'b101, 3);
        rst_pulse();
        bit_in(1'b0);
        check("t4_cnt", 32'(cnt), 0);

        // Length 1 with a 2-bit counter saturates.
        load(8'b1, 1, 1'b0);
        stream(8'b111, 3);
        check("t5_sat3", 32'(cnt_sat), 1);
        stream(8'b11, 2);
        check("t5_cnt", 32'(cnt), 3);

        // Load wins over a valid bit; length 12 clamps to 8.
        load(8'b1010, 4, 1'b0);
        stream(8'b101, 3);
        step(1'b1, 1'b1, 1'b1, 8'hA5, 4'd12, 1'b0);
        check("t6_cnt_clr", 32'(cnt), 0);
        stream(8'hA5, 8);
        check("t6_cnt", 32'(cnt), 1);
        check("t6_op_reg", 32'(op_reg), 1);

        // Random patterns, lengths, modes and valid gaps.
        for (int r = 0; r < 40; r++) begin
            rl = ($urandom_range(0, 4) == 0) ? LEN_W'($urandom_range(5, 15))
                                             : LEN_W'($urandom_range(0, 4));
            rp = 8'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, rp, rl,
                 1'($urandom_range(0, 1)));
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 49) == 0) begin
                    step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom),
                         LEN_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end else begin
                    step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                         pat_in, len_in, ovl_in);
                end
            end
        end

        repeat (2) idle();
        check("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
